// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants, channel-select type and round-robin helper
//               for the stream demux dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // NUM_CH is a power of two, so the natural overflow of SEL_W bits is the wrap
    function automatic ch_sel_t rr_next(input ch_sel_t ptr);
        return ptr + ch_sel_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_demux_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_dispatcher_if
// Description : Upstream handshake, per-channel output streams and control
//               signals of the stream demux dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_demux_dispatcher_if #(
    parameter int DATA_W = 8
);
    import demux_pkg::*;

    logic                     flush;
    logic                     rr_mode;
    logic [DATA_W-1:0]        in_data;
    ch_sel_t                  in_sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    ch_sel_t                  cur_sel;
    ch_sel_t                  rr_ptr;

    modport slave (
        input  flush, rr_mode, in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, cur_sel, rr_ptr
    );

    modport master (
        output flush, rr_mode, in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, cur_sel, rr_ptr
    );

endinterface
`default_nettype wire

// File: rtl/demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_out_slot
// Description : One-deep registered output slot with load/drain handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush_i,
    input  wire logic              load_i,
    input  wire logic [DATA_W-1:0] data_i,
    input  wire logic              ready_i,
    output logic                   valid_o,
    output logic [DATA_W-1:0]      data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Load takes priority over drain so a same-cycle drain+refill keeps valid high
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/stream_demux_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_dispatcher
// Description : Steers one input stream into four one-deep output slots by
//               tag or round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    stream_demux_dispatcher_if.slave bus
);

    ch_sel_t                  w_tgt;
    logic                     w_in_ready;
    logic                     w_accept;
    logic [NUM_CH-1:0]        w_valid;
    logic [NUM_CH*DATA_W-1:0] w_data;
    ch_sel_t                  rr_ptr_q, rr_ptr_d;

    assign w_tgt      = bus.rr_mode ? rr_ptr_q : bus.in_sel;
    // Only the targeted slot gates acceptance; other channels never stall input
    assign w_in_ready = !bus.flush && (!w_valid[w_tgt] || bus.out_ready[w_tgt]);
    assign w_accept   = bus.in_valid && w_in_ready;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
            demux_out_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush_i (bus.flush),
                .load_i  (w_accept && (w_tgt == ch_sel_t'(g))),
                .data_i  (bus.in_data),
                .ready_i (bus.out_ready[g]),
                .valid_o (w_valid[g]),
                .data_o  (w_data[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (bus.flush) begin
            rr_ptr_d = '0;
        end else if (w_accept && bus.rr_mode) begin
            rr_ptr_d = rr_next(rr_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign bus.cur_sel   = w_tgt;
    assign bus.rr_ptr    = rr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_dispatcher
// Description : Scoreboard bench for the stream demux dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_dispatcher;

    typedef logic [7:0] byte_t;

    logic  clk;
    logic  rst_n;
    int    pass_cnt;
    int    total_cnt;
    byte_t exp_q [4][$];

    stream_demux_dispatcher_if #(.DATA_W(8)) bus ();

    stream_demux_dispatcher #(
        .DATA_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic byte_t slice(input int n);
        return bus.out_data[n*8 +: 8];
    endfunction

    // Scoreboard drain side: every completed output handshake pops its channel queue
    always @(negedge clk) begin
        byte_t e;
        if (rst_n && !bus.flush) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.out_valid[n] && bus.out_ready[n]) begin
                    total_cnt++;
                    if (exp_q[n].size() == 0) begin
                        $display("FAIL drain_ch%0d: got word %h, expected no word", n, slice(n));
                    end else begin
                        e = exp_q[n].pop_front();
                        if (slice(n) !== e)
                            $display("FAIL drain_ch%0d: got %h, expected %h", n, slice(n), e);
                        else
                            pass_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        for (int n = 0; n < 4; n++) exp_q[n].delete();
    endtask

    // Present one word for one cycle; compare steering and readiness against the model
    task automatic send(input byte_t d, input logic [1:0] sel,
                        input logic [1:0] exp_ch, input logic exp_rdy);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = sel;
        @(negedge clk);
        total_cnt++;
        if (bus.cur_sel !== exp_ch)
            $display("FAIL cur_sel(word %h): got %0d, expected %0d", d, bus.cur_sel, exp_ch);
        else
            pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== exp_rdy)
            $display("FAIL in_ready(word %h): got %b, expected %b", d, bus.in_ready, exp_rdy);
        else
            pass_cnt++;
        if (bus.in_ready === 1'b1) exp_q[exp_ch].push_back(d);
        tick();
    endtask

    task automatic test_reset();
        #12;
        total_cnt++;
        if (bus.out_valid !== 4'b0000 || bus.rr_ptr !== 2'd0 || bus.out_data !== 32'h0)
            $display("FAIL reset_state: got valid=%b ptr=%0d data=%h, expected 0/0/0",
                     bus.out_valid, bus.rr_ptr, bus.out_data);
        else
            pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        else
            pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_tag_routing();
        byte_t d [4];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        bus.rr_mode   = 1'b0;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            send(d[i], 2'(i), 2'(i), 1'b1);
            total_cnt++;
            if (bus.out_valid !== 4'(1 << i) || slice(i) !== d[i])
                $display("FAIL tag_ch%0d: got valid=%b data=%h, expected valid=%b data=%h",
                         i, bus.out_valid, slice(i), 4'(1 << i), d[i]);
            else
                pass_cnt++;
        end
        bus.in_valid = 1'b0;
        tick();
        total_cnt++;
        if (bus.out_valid !== 4'b0000)
            $display("FAIL tag_drained: got %b, expected 0000", bus.out_valid);
        else
            pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.rr_mode   = 1'b0;
        bus.out_ready = 4'b1011;
        send(8'hA5, 2'd2, 2'd2, 1'b1);
        send(8'h5A, 2'd2, 2'd2, 1'b0);
        total_cnt++;
        if (bus.out_valid[2] !== 1'b1 || slice(2) !== 8'hA5)
            $display("FAIL bp_hold: got valid2=%b data=%h, expected 1 a5", bus.out_valid[2], slice(2));
        else
            pass_cnt++;
        bus.in_valid = 1'b0;
        tick();
        send(8'h77, 2'd1, 2'd1, 1'b1);
        send(8'h5A, 2'd2, 2'd2, 1'b0);
        bus.out_ready = 4'b1111;
        send(8'h5A, 2'd2, 2'd2, 1'b1);
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid[2] !== 1'b1 || slice(2) !== 8'h5A)
            $display("FAIL bp_refill: got valid2=%b data=%h, expected 1 5a", bus.out_valid[2], slice(2));
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if (bus.out_valid !== 4'b0000)
            $display("FAIL bp_drained: got %b, expected 0000", bus.out_valid);
        else
            pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] p;
        p = 2'd0;
        bus.rr_mode   = 1'b1;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            send(byte_t'(i + 1), 2'd3, p, 1'b1);
            p = p + 2'd1;
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.rr_ptr !== 2'd2)
            $display("FAIL rr_wrap_ptr: got %0d, expected 2", bus.rr_ptr);
        else
            pass_cnt++;
        tick();
        bus.out_ready = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            send(byte_t'(8'h07 + i), 2'd1, p, 1'b1);
            p = p + 2'd1;
        end
        send(8'h0D, 2'd1, 2'd0, 1'b0);
        send(8'h0D, 2'd1, 2'd0, 1'b0);
        total_cnt++;
        if (bus.rr_ptr !== 2'd0)
            $display("FAIL rr_stall_ptr: got %0d, expected 0", bus.rr_ptr);
        else
            pass_cnt++;
        bus.out_ready = 4'b1111;
        send(8'h0D, 2'd1, 2'd0, 1'b1);
        bus.in_valid = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (bus.rr_ptr !== 2'd1 || bus.out_valid !== 4'b0000)
            $display("FAIL rr_after_stall: got ptr=%0d valid=%b, expected 1 0000",
                     bus.rr_ptr, bus.out_valid);
        else
            pass_cnt++;
    endtask

    task automatic test_mode_switch();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        total_cnt++;
        if (bus.rr_ptr !== 2'd0)
            $display("FAIL ms_flush_ptr: got %0d, expected 0", bus.rr_ptr);
        else
            pass_cnt++;
        bus.rr_mode = 1'b1;
        send(8'h21, 2'd2, 2'd0, 1'b1);
        send(8'h22, 2'd2, 2'd1, 1'b1);
        send(8'h23, 2'd2, 2'd2, 1'b1);
        bus.rr_mode = 1'b0;
        send(8'h24, 2'd1, 2'd1, 1'b1);
        total_cnt++;
        if (bus.rr_ptr !== 2'd3 || slice(1) !== 8'h24)
            $display("FAIL ms_tag: got ptr=%0d data1=%h, expected 3 24", bus.rr_ptr, slice(1));
        else
            pass_cnt++;
        bus.rr_mode = 1'b1;
        send(8'h25, 2'd0, 2'd3, 1'b1);
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.rr_ptr !== 2'd0 || slice(3) !== 8'h25)
            $display("FAIL ms_back_rr: got ptr=%0d data3=%h, expected 0 25", bus.rr_ptr, slice(3));
        else
            pass_cnt++;
        tick();
    endtask

    task automatic test_flush();
        bus.out_ready = 4'b0000;
        bus.rr_mode   = 1'b1;
        send(8'h31, 2'd0, 2'd0, 1'b1);
        send(8'h32, 2'd0, 2'd1, 1'b1);
        send(8'h33, 2'd0, 2'd2, 1'b1);
        bus.rr_mode = 1'b0;
        send(8'h34, 2'd3, 2'd3, 1'b1);
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 4'b1111 || bus.rr_ptr !== 2'd3)
            $display("FAIL fl_full: got valid=%b ptr=%0d, expected 1111 3", bus.out_valid, bus.rr_ptr);
        else
            pass_cnt++;
        bus.flush = 1'b1;
        send(8'hEE, 2'd3, 2'd3, 1'b0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        clear_queues();
        total_cnt++;
        if (bus.out_valid !== 4'b0000 || bus.rr_ptr !== 2'd0 || slice(3) !== 8'h34)
            $display("FAIL fl_after: got valid=%b ptr=%0d data3=%h, expected 0000 0 34",
                     bus.out_valid, bus.rr_ptr, slice(3));
        else
            pass_cnt++;
        bus.out_ready = 4'b1111;
        tick();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 4'b0000;
        bus.rr_mode   = 1'b1;
        send(8'h41, 2'd3, 2'd0, 1'b1);
        send(8'h42, 2'd3, 2'd1, 1'b1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 4'b0000 || bus.out_data !== 32'h0 || bus.rr_ptr !== 2'd0)
            $display("FAIL async_reset: got valid=%b data=%h ptr=%0d, expected 0/0/0",
                     bus.out_valid, bus.out_data, bus.rr_ptr);
        else
            pass_cnt++;
        clear_queues();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 4'b1111;
        send(8'h51, 2'd2, 2'd0, 1'b1);
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 4'b0001 || slice(0) !== 8'h51)
            $display("FAIL post_reset_route: got valid=%b data0=%h, expected 0001 51",
                     bus.out_valid, slice(0));
        else
            pass_cnt++;
        tick();
        tick();
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.rr_mode   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0000;

        test_reset();
        test_tag_routing();
        test_backpressure();
        test_round_robin();
        test_mode_switch();
        test_flush();
        test_async_reset();

        total_cnt++;
        if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0)
            $display("FAIL scoreboard_empty: got %0d/%0d/%0d/%0d words left, expected none",
                     exp_q[0].size(), exp_q[1].size(), exp_q[2].size(), exp_q[3].size());
        else
            pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_demux_dispatcher.md
Name: stream_demux_dispatcher

Overview:
Sequential front end for the 1-to-4 demultiplexer. It accepts a data word plus a 2-bit destination over a valid/ready handshake and steers it into one of four one-deep output slots, each with its own valid/ready handshake. Routing is either by the tag supplied with the word (tag mode) or by an internal round-robin pointer. Downstream consumers see registered, stall-safe per-channel streams.

Parameters:
DATA_W, 8, width of each data word and of each output channel slice.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous flush; clears all slots and the round-robin pointer.
rr_mode  input  1  1 = round-robin routing, 0 = tag routing via in_sel.
in_data  input  DATA_W  input word.
in_sel  input  2  destination channel; used only when rr_mode=0.
in_valid  input  1  input word present.
in_ready  output  1  dispatcher can accept this cycle (combinational).
out_data  output  4*DATA_W  channel n occupies bits [n*DATA_W +: DATA_W].
out_valid  output  4  per-channel slot full.
out_ready  input  4  per-channel consumer ready.
cur_sel  output  2  channel targeted this cycle (rr_ptr or in_sel).
rr_ptr  output  2  current round-robin pointer.

Behaviour:
- Reset (rst_n=0, asynchronous) sets out_valid=0, out_data=0, rr_ptr=0. Release is synchronous to clk. Reset mid-transfer drops every buffered word.
- Target selection: tgt = rr_mode ? rr_ptr : in_sel. cur_sel = tgt at all times, including when in_valid=0.
- in_ready = !flush && (!out_valid[tgt] || out_ready[tgt]). in_ready never depends on non-targeted channels.
- Accept = in_valid && in_ready. On accept:
  - slice tgt of out_data <= in_data;
  - out_valid[tgt] <= 1 on the next edge, so latency from accept to out_valid is 1 cycle.
- Drain: a channel whose out_valid[n] && out_ready[n] is high clears out_valid[n] on the next edge, unless that channel is accepting in the same cycle.
- Simultaneous drain and refill on the same channel: out_valid stays 1 and the new data is loaded. Full throughput is one word per cycle per channel.
- Channels drain independently. Any number of channels may drain in one cycle.
- out_data slices hold their last value when not loaded. A slice is meaningful only while its out_valid bit is 1. No zeroing on drain.
- Round-robin pointer: in rr_mode=1, rr_ptr increments by 1 on each accept and wraps from 3 to 0. It does not advance on a stalled cycle (in_valid=1, in_ready=0); the word waits for the same channel, with no skipping. In rr_mode=0, rr_ptr holds its value.
- rr_mode may change on any cycle and takes effect combinationally that cycle. rr_ptr is preserved across mode changes.
- Flush (synchronous): on the next edge out_valid=0 and rr_ptr=0. in_ready=0 during the flush cycle, so flush wins over a simultaneous accept. out_data is not cleared.
- in_sel is ignored when rr_mode=1, and in_data is ignored when no accept occurs.
- Valid/ready rules:
  - Once out_valid[n] rises, the slot's data is stable until the handshake completes.
  - The upstream side must hold in_data and in_sel stable while in_valid=1 and in_ready=0.

Decomposition:
- Shared package demux_pkg:
  - constants NUM_CH=4 and SEL_W=2;
  - typedef ch_sel_t (logic [SEL_W-1:0]);
  - function for the round-robin increment with wrap.
- One natural sub-module, demux_out_slot: a one-deep register slot with load, data_in, ready and flush inputs and valid/data outputs, instantiated 4 times.
- The top level holds the target mux, the in_ready logic and the rr_ptr register.

Test Plan:
- Tag routing, all out_ready=1. Send 0x11, 0x22, 0x33, 0x44 with in_sel=0,1,2,3 on consecutive cycles -> each out_valid[n] pulses one cycle after its accept; slice n = 0x11/0x22/0x33/0x44; in_ready stays 1.
- Backpressure. out_ready[2]=0, send 0xA5 then 0x5A to channel 2 -> first accepted; in_ready=0 for the second; a word to channel 1 in the same period is accepted. Raising out_ready[2] accepts 0x5A on that same cycle, and out_valid[2] stays 1 throughout.
- Round-robin wrap. rr_mode=1, send 6 words 0x01..0x06 -> channels 0,1,2,3,0,1 in order; rr_ptr reads 2 afterwards. A stall on channel 0 (out_ready[0]=0, slot full) holds rr_ptr at 0 with no skip.
- Mode switch. 3 words in rr_mode=1 (rr_ptr=3), then rr_mode=0 with in_sel=1 -> word goes to channel 1 and rr_ptr stays 3. Back to rr_mode=1 -> the next word goes to channel 3.
- Flush versus accept. All slots full, flush=1 with in_valid=1 -> in_ready=0, no load; next cycle out_valid=4'b0000 and rr_ptr=0.
- Async reset mid-stream. Assert rst_n=0 between edges with slots full -> out_valid=0, out_data=0, rr_ptr=0 immediately. After release, the first accepted word routes per rr_ptr=0.
